// File: rtl/line_mem_port_if.sv
// Line-transfer bus between the cache controller (master) and the memory port (slave).
// Carries request (valid/ready/we/addr), write-beat (valid/data/ready),
// refill-beat (valid/data) and status (done/busy) signals.
interface line_mem_port_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned WORD_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic              wr_valid;
  logic [WORD_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_valid;
  logic [WORD_W-1:0] rd_data;
  logic              done;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, wr_valid, wr_data,
    input  req_ready, wr_ready, rd_valid, rd_data, done, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, wr_valid, wr_data,
    output req_ready, wr_ready, rd_valid, rd_data, done, busy
  );
endinterface

// File: rtl/line_mem_port.sv
// Main-memory port behind the cache controller. Accepts one whole-line
// refill or write-back at a time, waits LAT cycles, then streams the line as
// LINE_WORDS beats from/to a word-addressed backing store of 2^DEPTH_W words.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - line_mem_port_if slave modport (request, write beats, refill beats,
//          done pulse, busy flag); all bus outputs are registered.
module line_mem_port #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned LAT        = 3,
  parameter int unsigned DEPTH_W    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  line_mem_port_if.slave       bus
);

  localparam int unsigned OFF_W     = $clog2(LINE_WORDS);
  localparam int unsigned LAT_W     = 4;
  localparam int unsigned MEM_WORDS = 2 ** DEPTH_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RBURST,
    S_WBURST,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              we_q, we_d;

  logic              req_ready_q, req_ready_d;
  logic              wr_ready_q, wr_ready_d;
  logic              rd_valid_q, rd_valid_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic [WORD_W-1:0]  mem [MEM_WORDS];
  logic [DEPTH_W-1:0] rd_idx_c;
  logic [DEPTH_W-1:0] wr_idx_c;
  logic               mem_we_c;

  localparam logic [OFF_W-1:0]  LAST_BEAT = OFF_W'(LINE_WORDS - 1);
  localparam logic [LAT_W-1:0]  LAST_LAT  = LAT_W'(LAT - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS - 1);

  // State and registered-output flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lat_cnt_q   <= '0;
      beat_q      <= '0;
      base_q      <= '0;
      we_q        <= 1'b0;
      req_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      beat_q      <= beat_d;
      base_q      <= base_d;
      we_q        <= we_d;
      req_ready_q <= req_ready_d;
      wr_ready_q  <= wr_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, latency and beat counters
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    beat_d    = beat_q;
    base_d    = base_q;
    we_d      = we_q;
    case (state_q)
      S_IDLE: begin
        // req_ready is high exactly in IDLE, so req_valid alone is acceptance
        if (bus.req_valid) begin
          base_d    = bus.req_addr & ~LINE_MASK;
          we_d      = bus.req_we;
          lat_cnt_d = '0;
          beat_d    = '0;
          if (LAT == 0) begin
            state_d = bus.req_we ? S_WBURST : S_RBURST;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (lat_cnt_q == LAST_LAT) begin
          state_d = we_q ? S_WBURST : S_RBURST;
          beat_d  = '0;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      S_RBURST: begin
        if (beat_q == LAST_BEAT) begin
          state_d = S_DONE;
        end else begin
          beat_d = beat_q + OFF_W'(1);
        end
      end
      S_WBURST: begin
        // Gaps in wr_valid simply hold the beat counter
        if (bus.wr_valid) begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_DONE;
          end else begin
            beat_d = beat_q + OFF_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the upcoming state so they line up
  // with the state they describe
  always_comb begin
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    wr_ready_d  = (state_d == S_WBURST);
    rd_valid_d  = (state_d == S_RBURST);
    done_d      = (state_d == S_DONE);
    // Upper address bits drop out here, which gives both aliasing and
    // wrap-around within the store
    rd_idx_c    = DEPTH_W'(base_d + ADDR_W'(beat_d));
    rd_data_d   = rd_valid_d ? mem[rd_idx_c] : rd_data_q;
  end

  assign wr_idx_c = DEPTH_W'(base_q + ADDR_W'(beat_q));
  assign mem_we_c = (state_q == S_WBURST) && bus.wr_valid;

  // Backing store; deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[wr_idx_c] <= bus.wr_data;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.wr_ready  = wr_ready_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_line_mem_port.sv
module tb_line_mem_port;

  localparam int LAT = 3;
  localparam int LW  = 4;

  typedef struct {
    bit               we;
    bit               gaps;
    logic [15:0]      addr;
    logic [3:0][31:0] data;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  line_mem_port_if #(.ADDR_W(16), .WORD_W(32)) bus ();

  line_mem_port #(
    .ADDR_W(16), .WORD_W(32), .LINE_WORDS(LW), .LAT(LAT), .DEPTH_W(10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Results of the most recent run_txn
  int               first_rdy, first_rv, n_rd, done_c, n_done, last_acc, beats, busy_bad;
  logic [3:0][31:0] rd_got;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0][31:0] mk(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  // One line transaction; records timing and refill data, cycle 0 = acceptance
  task automatic run_txn(input bit we, input bit gaps, input logic [15:0] addr,
                         input logic [3:0][31:0] wd);
    int c;
    bit fin;
    first_rdy = -1; first_rv = -1; n_rd = 0; done_c = -1; n_done = 0;
    last_acc = -1; beats = 0; busy_bad = 0; rd_got = '0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.wr_valid  = 1'b0;
    @(negedge clk);
    chk("req_ready_idle", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    c = 1;
    fin = 1'b0;
    while (!fin && c <= 40) begin
      bus.wr_valid = we && (!gaps || (c % 2 == 0)) && (beats < LW);
      if (beats < LW) bus.wr_data = wd[beats];
      @(negedge clk);
      if (bus.wr_ready && first_rdy < 0) first_rdy = c;
      if (bus.wr_valid && bus.wr_ready) begin
        beats++;
        last_acc = c;
      end
      if (bus.rd_valid) begin
        if (first_rv < 0) first_rv = c;
        if (n_rd < LW) rd_got[n_rd] = bus.rd_data;
        n_rd++;
      end
      if (bus.done) begin
        n_done++;
        if (done_c < 0) done_c = c;
        fin = 1'b1;
      end
      if (!bus.busy || bus.req_ready) busy_bad++;
      @(posedge clk); #1;
      c++;
    end
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("busy_after_done", bus.busy, 0);
    chk("req_ready_after_done", bus.req_ready, 1);
    chk("done_single_pulse", bus.done, 0);
    if (!we) chk("rd_data_hold", bus.rd_data, rd_got[3]);
  endtask

  vec_t vecs[7];

  initial begin
    logic [3:0][31:0] a_d, g_d, h_d, b_d, c_d;
    int a0, a1, bad;
    checks = 0;
    errors = 0;
    a_d = mk(32'hA000_0000);
    g_d = mk(32'h6000_0000);
    h_d = mk(32'h4000_0400);
    b_d = mk(32'hB000_0000);
    c_d = mk(32'hC000_0000);
    vecs[0] = '{we: 1'b1, gaps: 1'b0, addr: 16'h0013, data: a_d};
    vecs[1] = '{we: 1'b0, gaps: 1'b0, addr: 16'h0011, data: a_d};
    vecs[2] = '{we: 1'b1, gaps: 1'b1, addr: 16'h0031, data: g_d};
    vecs[3] = '{we: 1'b0, gaps: 1'b0, addr: 16'h0032, data: g_d};
    vecs[4] = '{we: 1'b1, gaps: 1'b0, addr: 16'h0400, data: h_d};
    vecs[5] = '{we: 1'b0, gaps: 1'b0, addr: 16'h0000, data: h_d};
    vecs[6] = '{we: 1'b0, gaps: 1'b0, addr: 16'h0010, data: a_d};

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Table-driven line transactions
    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].we, vecs[i].gaps, vecs[i].addr, vecs[i].data);
      chk("single_done", n_done, 1);
      chk("busy_ready_during_txn", busy_bad, 0);
      if (vecs[i].we) begin
        chk("wr_ready_first", first_rdy, LAT + 1);
        chk("beats_accepted", beats, LW);
        chk("done_after_last_beat", done_c, last_acc + 1);
        if (!vecs[i].gaps) chk("wr_done_cycle", done_c, LAT + LW + 1);
      end else begin
        chk("rd_valid_first", first_rv, LAT + 1);
        chk("rd_beat_count", n_rd, LW);
        chk("rd_done_cycle", done_c, LAT + LW + 1);
        for (int k = 0; k < LW; k++) chk("rd_beat_data", rd_got[k], vecs[i].data[k]);
      end
    end

    // Back-to-back requests with req_valid held high
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 16'h0010;
    a0 = -1; a1 = -1; bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.req_ready == bus.busy) bad++;
      if (bus.req_valid && bus.req_ready) begin
        if (a0 < 0) a0 = c;
        else if (a1 < 0) a1 = c;
      end
      @(posedge clk); #1;
      if (a1 >= 0) bus.req_valid = 1'b0;
    end
    chk("b2b_first_accept", a0, 0);
    chk("b2b_spacing", a1 - a0, LAT + LW + 2);
    chk("b2b_ready_vs_busy", bad, 0);

    // Reset in the middle of a write-back
    run_txn(1'b1, 1'b0, 16'h0020, b_d);
    chk("old_line_done", n_done, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 16'h0022;
    bus.wr_valid  = 1'b1;
    bus.wr_data   = c_d[0];
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_beat0_ready", bus.wr_ready, 1);
    @(posedge clk); #1;
    bus.wr_data = c_d[1];
    #2 rst = 1'b1;
    #1;
    chk("async_wr_ready", bus.wr_ready, 0);
    chk("async_busy", bus.busy, 0);
    chk("async_req_ready", bus.req_ready, 1);
    chk("async_done", bus.done, 0);
    chk("async_rd_data", bus.rd_data, 0);
    bus.wr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) bad++;
    end
    chk("no_done_after_abort", bad, 0);
    run_txn(1'b0, 1'b0, 16'h0021, '0);
    chk("abort_beat0_new", rd_got[0], c_d[0]);
    chk("abort_beat2_old", rd_got[2], b_d[2]);
    chk("abort_beat3_old", rd_got[3], b_d[3]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_mem_port.md
Name: line_mem_port

Overview:
- Main-memory port sitting directly downstream of the cache controller top.
- Services whole-line refills (reads) and whole-line write-backs (writes) issued by the controller on a miss or dirty eviction.
- Holds a word-addressed backing store and returns or accepts a line as a burst of words after a fixed access latency.
- Single clock domain, no other masters.

Parameters:
- ADDR_W, 16, word-address width of req_addr.
- WORD_W, 32, data word width.
- LINE_WORDS, 4, words per cache line; power of two, at least 2.
- LAT, 3, idle cycles between request acceptance and the first data beat; 0 to 15.
- DEPTH_W, 10, backing store holds 2^DEPTH_W words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  controller presents a line request.
- req_ready  out  1  port can accept a request.
- req_we  in  1  1 = write-back, 0 = refill.
- req_addr  in  ADDR_W  word address of any word in the line.
- wr_valid  in  1  write beat present.
- wr_data  in  WORD_W  write beat data.
- wr_ready  out  1  port accepts a write beat.
- rd_valid  out  1  refill beat valid.
- rd_data  out  WORD_W  refill beat data.
- done  out  1  one-cycle pulse when the line transaction completes.
- busy  out  1  high from acceptance through the done cycle.

Behaviour:
- Reset, asynchronous:
  - FSM goes to IDLE.
  - req_ready=1; wr_ready, rd_valid, done, busy = 0; rd_data = 0.
  - Latency and beat counters clear.
  - Backing store is not cleared; its contents are undefined until written.
- FSM states: IDLE, WAIT, RBURST, WBURST, DONE.
- Handshake: a request is accepted when req_valid && req_ready. req_ready is high only in IDLE. req_valid in any other state is ignored, not queued.
- Acceptance in cycle T:
  - Latch base = req_addr with the low log2(LINE_WORDS) bits forced to 0.
  - Latch req_we.
  - Set busy in T+1.
  - If LAT>0, go to WAIT and hold there for LAT cycles. If LAT=0, go straight to the burst state.
- RBURST:
  - First rd_valid is in cycle T+LAT+1.
  - rd_valid stays high for exactly LINE_WORDS consecutive cycles. Beat k carries mem[(base+k) mod 2^DEPTH_W].
  - No backpressure: the controller must sample every beat.
  - rd_data is registered and holds its last value when rd_valid=0.
- WBURST:
  - wr_ready is high from cycle T+LAT+1 until the last beat is accepted.
  - A beat is accepted on wr_valid && wr_ready and written to (base+k) mod 2^DEPTH_W, with k counting 0..LINE_WORDS-1.
  - Gaps in wr_valid are allowed and stall the counter.
  - wr_valid outside WBURST is ignored.
- DONE: after the last beat, spend one cycle in DONE with done=1 and busy=1, then go to IDLE.
  - The earliest next acceptance is the cycle after DONE.
  - Minimum request-to-request spacing is LAT+LINE_WORDS+2 cycles.
- Address rules:
  - Store index = low DEPTH_W bits of the word address.
  - Bits of the address above DEPTH_W alias.
  - The beat offset wraps within the store, not within the line: base is always line-aligned, so the line never crosses the store boundary when DEPTH_W >= log2(LINE_WORDS).
- Reset mid-operation: abort immediately. Beats already written remain in the store; no done pulse.
- Read-after-write: a refill accepted after a write-back's done returns the newly written data.

Test Plan:
1. Reset, then write-back: req_we=1, req_addr=0x0013, LAT=3, wr_valid held high with data A0..A3.
   - Accept at T; wr_ready high from T+4.
   - Words stored at 0x10..0x13; done pulse at T+8; busy low at T+9.
2. Refill of req_addr=0x0011 after scenario 1.
   - rd_valid high T+4..T+7 with A0,A1,A2,A3.
   - done at T+8; req_ready high at T+9.
3. Write-back with wr_valid low on alternate cycles.
   - Exactly 4 beats stored in order; done one cycle after the 4th accepted beat.
   - No beat is double-counted.
4. Aliasing: write at req_addr=0x0400 (DEPTH_W=10), then refill at 0x0000.
   - The refill returns the data just written.
5. req_valid held high continuously for two requests.
   - The second is accepted only in IDLE after DONE, spacing exactly LAT+LINE_WORDS+2 = 9 cycles.
   - req_ready=0 throughout busy.
6. Assert rst during the 2nd beat of a write-back.
   - All outputs return to reset values asynchronously; no done pulse.
   - A subsequent refill of that line returns beat 0 new and beats 2..3 old.
